// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared types and constants for the 6502 internal bus driver
package cpu_bus_pkg;

    localparam int CONTENTION_CNT_W = 16;
    localparam logic [7:0] DEFAULT_PRECHARGE = 8'hFF;

    typedef enum logic [1:0] {
        DRIVEN     = 2'd0,
        HOLDING    = 2'd1,
        PRECHARGED = 2'd2
    } bus_retention_e;

    function automatic logic [CONTENTION_CNT_W-1:0] sat_inc(
        input logic [CONTENTION_CNT_W-1:0] value
    );
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/cpu_bus_priority_enc.sv
// rtl/cpu_bus_priority_enc.sv - lowest-index-wins encoder over bus drive enables
module cpu_bus_priority_enc #(
    parameter int NUM_SRC  = 6,
    parameter bit MULTI_EN = 1'b1,
    localparam int IDX_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] src_en,
    output logic               any,
    output logic [IDX_W-1:0]   index,
    output logic               multi
);

    always_comb begin
        any   = |src_en;
        index = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src_en[i]) begin
                index = IDX_W'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more enables are up.
    generate
        if (MULTI_EN) begin : g_multi
            assign multi = |(src_en & (src_en - 1'b1));
        end else begin : g_no_multi
            assign multi = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/cpu_internal_bus.sv
// rtl/cpu_internal_bus.sv - registered priority bus driver with NMOS retention; CPU_BUS_CONTENTION_CHECK_EN adds contention tracking
module cpu_internal_bus
    import cpu_bus_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               NUM_SRC     = 6,
    parameter int               HOLD_CYCLES = 2,
    parameter logic [WIDTH-1:0] PRECHARGE   = WIDTH'(DEFAULT_PRECHARGE),
    localparam int              SRC_W       = $clog2(NUM_SRC)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_SRC-1:0]          src_en,
    input  logic [NUM_SRC*WIDTH-1:0]    src_data,
    input  logic                        clear_err,
    output logic [WIDTH-1:0]            bus_out,
    output logic                        bus_driven,
    output logic [SRC_W-1:0]            bus_src,
    output logic                        contention,
    output logic [CONTENTION_CNT_W-1:0] contention_cnt
);

    localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

`ifdef CPU_BUS_CONTENTION_CHECK_EN
    localparam bit CONTENTION_EN = 1'b1;
`else
    localparam bit CONTENTION_EN = 1'b0;
`endif

    logic                 enc_any;
    logic                 enc_multi;
    logic [SRC_W-1:0]     enc_idx;
    logic [WIDTH-1:0]     src_word [NUM_SRC];
    logic [HOLD_W-1:0]    hold_cnt;
    logic                 hold_left;
    bus_retention_e       ret_state;

    cpu_bus_priority_enc #(
        .NUM_SRC  (NUM_SRC),
        .MULTI_EN (CONTENTION_EN)
    ) u_prio (
        .src_en (src_en),
        .any    (enc_any),
        .index  (enc_idx),
        .multi  (enc_multi)
    );

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            src_word[i] = src_data[i*WIDTH +: WIDTH];
        end
    end

    // Retention state is implied by bus_driven and hold_cnt rather than kept in its own register.
    assign hold_left = (hold_cnt < HOLD_MAX);

    always_comb begin
        if (bus_driven) begin
            ret_state = DRIVEN;
        end else if (hold_left) begin
            ret_state = HOLDING;
        end else begin
            ret_state = PRECHARGED;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_out    <= PRECHARGE;
            bus_driven <= 1'b0;
            bus_src    <= '0;
            hold_cnt   <= '0;
        end else if (enc_any) begin
            bus_out    <= src_word[enc_idx];
            bus_driven <= 1'b1;
            bus_src    <= enc_idx;
            hold_cnt   <= '0;
        end else begin
            bus_driven <= 1'b0;
            if (ret_state != PRECHARGED && hold_left) begin
                hold_cnt <= hold_cnt + 1'b1;
            end else begin
                bus_out  <= PRECHARGE;
                hold_cnt <= HOLD_MAX;
            end
        end
    end

`ifdef CPU_BUS_CONTENTION_CHECK_EN
    // A contention event in the same cycle as clear_err restarts the count at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            contention     <= 1'b0;
            contention_cnt <= '0;
        end else if (enc_multi) begin
            contention     <= 1'b1;
            contention_cnt <= clear_err ? CONTENTION_CNT_W'(1) : sat_inc(contention_cnt);
        end else if (clear_err) begin
            contention     <= 1'b0;
            contention_cnt <= '0;
        end
    end
`else
    logic unused_contention;

    assign contention        = 1'b0;
    assign contention_cnt    = '0;
    assign unused_contention = ^{clear_err, enc_multi};
`endif

endmodule

// File: tb/tb_cpu_internal_bus.sv
// tb/tb_cpu_internal_bus.sv - scoreboard bench for cpu_internal_bus (HOLD_CYCLES 2 and 0 instances)
`timescale 1ns/1ps
module tb_cpu_internal_bus;
    import cpu_bus_pkg::*;

    localparam int W = 8;
    localparam int N = 6;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [N-1:0]   src_en = '0;
    logic [N*W-1:0] src_data = '0;
    logic           clear_err = 1'b0;

    logic [W-1:0]   h2_out, h0_out;
    logic           h2_drv, h0_drv;
    logic [2:0]     h2_src, h0_src;
    logic           h2_con, h0_con;
    logic [15:0]    h2_cnt, h0_cnt;

    cpu_internal_bus #(.WIDTH(W), .NUM_SRC(N), .HOLD_CYCLES(2), .PRECHARGE(8'hFF)) dut (
        .clk(clk), .rst_n(rst_n), .src_en(src_en), .src_data(src_data), .clear_err(clear_err),
        .bus_out(h2_out), .bus_driven(h2_drv), .bus_src(h2_src),
        .contention(h2_con), .contention_cnt(h2_cnt)
    );

    cpu_internal_bus #(.WIDTH(W), .NUM_SRC(N), .HOLD_CYCLES(0), .PRECHARGE(8'hFF)) dut0 (
        .clk(clk), .rst_n(rst_n), .src_en(src_en), .src_data(src_data), .clear_err(clear_err),
        .bus_out(h0_out), .bus_driven(h0_drv), .bus_src(h0_src),
        .contention(h0_con), .contention_cnt(h0_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  out2;
        logic [7:0]  out0;
        logic        drv;
        logic [2:0]  src;
        logic        con;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: last value on each bus, undriven run length, contention status.
    logic [7:0]  m_out2, m_out0;
    logic        m_drv;
    logic [2:0]  m_src;
    int          m_idle;
    logic        m_con;
    logic [15:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic exp_t snap();
        exp_t e;
        e.out2 = m_out2; e.out0 = m_out0; e.drv = m_drv; e.src = m_src;
        e.con = m_con;   e.cnt = m_cnt;
        return e;
    endfunction

    task automatic model_reset();
        m_out2 = 8'hFF; m_out0 = 8'hFF; m_drv = 1'b0; m_src = 3'd0;
        m_idle = 0; m_con = 1'b0; m_cnt = 16'd0;
    endtask

    task automatic model_step(input logic [N-1:0] en, input logic [N*W-1:0] data, input logic clr);
        int w;
        int ones;
        if (en != 0) begin
            w = 0;
            while (!en[w]) w++;
            m_out2 = data[w*W +: W];
            m_out0 = m_out2;
            m_drv  = 1'b1;
            m_src  = 3'(w);
            m_idle = 0;
        end else begin
            m_drv = 1'b0;
            if (m_idle < 1000) m_idle++;
            if (m_idle > 2) m_out2 = 8'hFF;
            if (m_idle > 0) m_out0 = 8'hFF;
        end
`ifdef CPU_BUS_CONTENTION_CHECK_EN
        ones = $countones(en);
        if (clr) begin
            m_con = 1'b0;
            m_cnt = 16'd0;
        end
        if (ones > 1) begin
            m_con = 1'b1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
`else
        ones = 0;
        m_con = 1'b0;
        m_cnt = 16'd0;
`endif
    endtask

    task automatic step(input logic [N-1:0] en, input logic [N*W-1:0] data, input logic clr);
        @(negedge clk);
        rst_n = 1'b1; src_en = en; src_data = data; clear_err = clr;
        model_step(en, data, clr);
        sb.push_back(snap());
    endtask

    // Reset asserted between edges so the asynchronous path is observed directly.
    task automatic do_reset(input int cycles);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        src_en = '1;
        #1;
        chk("async_rst_out", h2_out, 8'hFF);
        chk("async_rst_drv", h2_drv, 1'b0);
        chk("async_rst_cnt", h2_cnt, 16'd0);
        model_reset();
        repeat (cycles) begin
            @(negedge clk);
            src_en = '1;
            sb.push_back(snap());
        end
    endtask

    function automatic logic [N*W-1:0] rand_data();
        return {$urandom, $urandom};
    endfunction

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("bus_out",    h2_out, e.out2);
            chk("bus_driven", h2_drv, e.drv);
            chk("bus_src",    h2_src, e.src);
            chk("contention", h2_con, e.con);
            chk("cont_cnt",   h2_cnt, e.cnt);
            chk("h0_bus_out", h0_out, e.out0);
        end
    end

    initial begin
        logic [N*W-1:0] d;
        model_reset();

        d = rand_data();
        d[7:0] = 8'h5A;
        src_data = d;
        do_reset(2);
        step(6'b111111, d, 1'b0);
        step(6'b000000, rand_data(), 1'b1);

        d = rand_data();
        d[2*W +: W] = 8'h3C;
        d[3*W +: W] = 8'hA5;
        step(6'b101100, d, 1'b0);

        d = rand_data();
        d[4*W +: W] = 8'h42;
        step(6'b010000, d, 1'b0);
        repeat (4) step(6'b000000, rand_data(), 1'b0);

        for (int i = 0; i < 400; i++) begin
            logic [N-1:0] en;
            en = ($urandom_range(0, 2) == 0) ? 6'b0 : 6'($urandom);
            if (i == 200) do_reset(1);
            step(en, rand_data(), ($urandom_range(0, 15) == 0));
        end

        step(6'b000000, rand_data(), 1'b1);
        repeat (65534) step(6'b000011, rand_data(), 1'b0);
        repeat (3) step(6'b110000, rand_data(), 1'b0);
        step(6'b000000, rand_data(), 1'b1);
        step(6'b000101, rand_data(), 1'b1);

        repeat (3) @(posedge clk);
        #2;
        chk("sb_drain", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
